udb_chain_ctrl: RTL

//  Run/stop controller for a DIGITS-wide chained BCD up/down counter.

---
 rtl/udb_chain_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/udb_chain_ctrl.sv
// Run/stop controller for a chained BCD up/down counter with prescaled stepping
// and a req/ack digit-serial preset load.
module udb_chain_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                  udb_chain_ctrl_clk,
  input  logic                  udb_chain_ctrl_rst,
  input  logic                  udb_chain_ctrl_start,
  input  logic                  udb_chain_ctrl_stop,
  input  logic                  udb_chain_ctrl_direction,
  input  logic                  udb_chain_ctrl_load_req,
  input  logic [3:0]            udb_chain_ctrl_load_digit,
  output logic                  udb_chain_ctrl_load_ack,
  output logic                  udb_chain_ctrl_running,
  output logic                  udb_chain_ctrl_tc,
  output logic [4*DIGITS-1:0]   udb_chain_ctrl_out
);

  localparam int unsigned OW = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [OW-1:0]   dig_q, dig_d;
  logic            ack_d, tc_d, run_d;

  logic [OW-1:0]   step_val;
  logic            step_wrap;
  logic            carry;
  logic [3:0]      ld_val;

  // Ripple one step through the chain; carry out of the top digit is a wrap.
  always_comb begin
    step_val = dig_q;
    carry    = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (udb_chain_ctrl_direction) begin
          if (dig_q[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = dig_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig_q[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = dig_q[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    step_wrap = carry;
  end

  assign ld_val = (udb_chain_ctrl_load_digit > 4'd9) ? 4'd9 : udb_chain_ctrl_load_digit;

  // Next-state and registered-output logic; priority load_req > stop > start.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    ack_d   = 1'b0;
    tc_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (udb_chain_ctrl_load_req) begin
          state_d = LOAD;
          idx_d   = '0;
        end else if (!udb_chain_ctrl_stop && udb_chain_ctrl_start) begin
          state_d = RUN;
          pre_d   = '0;
        end
      end
      RUN: begin
        if (udb_chain_ctrl_load_req) begin
          state_d = LOAD;
          idx_d   = '0;
          pre_d   = '0;
        end else if (udb_chain_ctrl_stop) begin
          state_d = IDLE;
          pre_d   = '0;
        end else if (pre_q == PW'(PRESCALE - 1)) begin
          pre_d = '0;
          dig_d = step_val;
          tc_d  = step_wrap;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      LOAD: begin
        if (udb_chain_ctrl_load_req && !udb_chain_ctrl_load_ack) begin
          for (int i = 0; i < int'(DIGITS); i++) begin
            if (IW'(i) == idx_q) dig_d[4*i +: 4] = ld_val;
          end
          ack_d = 1'b1;
          if (idx_q == IW'(DIGITS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d == RUN);
  end

  always_ff @(posedge udb_chain_ctrl_clk or posedge udb_chain_ctrl_rst) begin
    if (udb_chain_ctrl_rst) begin
      state_q                 <= IDLE;
      pre_q                   <= '0;
      idx_q                   <= '0;
      dig_q                   <= '0;
      udb_chain_ctrl_load_ack <= 1'b0;
      udb_chain_ctrl_running  <= 1'b0;
      udb_chain_ctrl_tc       <= 1'b0;
    end else begin
      state_q                 <= state_d;
      pre_q                   <= pre_d;
      idx_q                   <= idx_d;
      dig_q                   <= dig_d;
      udb_chain_ctrl_load_ack <= ack_d;
      udb_chain_ctrl_running  <= run_d;
      udb_chain_ctrl_tc       <= tc_d;
    end
  end

  assign udb_chain_ctrl_out = dig_q;

endmodule
